// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding, default
// value width and a small index-to-grant helper.
package counter_ctrl_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        RELEASE = 2'd3
    } seq_state_e;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that was not served last.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] pick
);

    // One-hot winner selection from the live request pair.
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last_served ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/counter_sequencer.sv
// Arbitrates two requesters for one shared up-counter and sequences
// load / count / terminal-count handling for the granted requester.
module counter_sequencer
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] start_val0,
    input  logic [WIDTH-1:0] start_val1,
    input  logic [WIDTH-1:0] term_val0,
    input  logic [WIDTH-1:0] term_val1,
    input  logic [1:0]       periodic,
    input  logic [WIDTH-1:0] cnt_value,
    output logic [1:0]       gnt,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_data,
    output logic             cnt_en,
    output logic [1:0]       done,
    output logic             busy
);

    seq_state_e       state_r;
    seq_state_e       state_nxt_s;
    logic             win_r;
    logic             win_nxt_s;
    logic             latch_s;
    logic             last_r;
    logic             periodic_r;
    logic [WIDTH-1:0] term_r;
    logic [WIDTH-1:0] term_sel_s;
    logic [1:0]       pick_s;
    logic [1:0]       win_oh_s;

    rr_arbiter_2 u_arb (
        .req         (req),
        .last_served (last_r),
        .pick        (pick_s)
    );

    assign win_oh_s   = idx_to_onehot(win_r);
    assign term_sel_s = win_nxt_s ? term_val1 : term_val0;
    assign busy       = (state_r != IDLE);

    // State, winner and per-transaction parameters; reset is active-high here.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r    <= IDLE;
            win_r      <= 1'b0;
            term_r     <= {WIDTH{1'b0}};
            periodic_r <= 1'b0;
            last_r     <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            if (latch_s) begin
                win_r      <= win_nxt_s;
                term_r     <= term_sel_s;
                periodic_r <= periodic[win_nxt_s];
            end
            if (state_r == RELEASE) begin
                last_r <= win_r;
            end
        end
    end

    // Next-state and output decode; the terminal compare uses live counter feedback.
    always_comb begin
        state_nxt_s = state_r;
        win_nxt_s   = win_r;
        latch_s     = 1'b0;
        gnt         = 2'b00;
        cnt_load    = 1'b0;
        cnt_data    = {WIDTH{1'b0}};
        cnt_en      = 1'b0;
        done        = 2'b00;
        case (state_r)
            IDLE: begin
                if (req != 2'b00) begin
                    win_nxt_s   = pick_s[1];
                    latch_s     = 1'b1;
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                gnt         = win_oh_s;
                cnt_load    = 1'b1;
                cnt_data    = win_r ? start_val1 : start_val0;
                state_nxt_s = RUN;
            end
            RUN: begin
                gnt = win_oh_s;
                if (!req[win_r]) begin
                    state_nxt_s = RELEASE;
                end else if (cnt_value == term_r) begin
                    done = win_oh_s;
                    // Reload only while the winner is the sole requester.
                    if (periodic_r && !req[~win_r]) begin
                        latch_s     = 1'b1;
                        state_nxt_s = LOAD;
                    end else begin
                        state_nxt_s = RELEASE;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            RELEASE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: stimulus pushes expected grant
// episodes, a negedge monitor reconstructs episodes from the DUT and compares.
module tb_counter_sequencer;

    localparam int W = 8;

    typedef struct {
        logic [1:0]   gnt;
        logic [W-1:0] data;
        int           n_en;
        bit           done;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req;
    logic [W-1:0] start_val0, start_val1, term_val0, term_val1;
    logic [1:0]   periodic;
    logic [W-1:0] cnt_value = '0;
    logic [1:0]   gnt;
    logic         cnt_load;
    logic [W-1:0] cnt_data;
    logic         cnt_en;
    logic [1:0]   done;
    logic         busy;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   timeouts = 0;
    bit   finished = 1'b0;

    // requester agents and reference model state (stimulus process only)
    logic [1:0]   active, permode, abort_en, raise_other, prev_done;
    int           dones [2];
    int           target [2];
    logic [W-1:0] abort_val [2];
    int           model_last;

    counter_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .start_val0 (start_val0),
        .start_val1 (start_val1),
        .term_val0  (term_val0),
        .term_val1  (term_val1),
        .periodic   (periodic),
        .cnt_value  (cnt_value),
        .gnt        (gnt),
        .cnt_load   (cnt_load),
        .cnt_data   (cnt_data),
        .cnt_en     (cnt_en),
        .done       (done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared counter being controlled: wraps modulo 2^W.
    always @(posedge clk) begin
        if (cnt_load) cnt_value <= cnt_data;
        else if (cnt_en) cnt_value <= cnt_value + 8'd1;
    end

    // ---------------- monitor / scoreboard ----------------
    logic         ep_active = 1'b0;
    logic [1:0]   ep_gnt;
    logic [W-1:0] ep_data;
    int           ep_en, ep_len;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_ep(input bit saw_done);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_episode", ep_gnt, 0);
        end else begin
            e = exp_q.pop_front();
            chk(ep_gnt == e.gnt, "grant", ep_gnt, e.gnt);
            chk(ep_data == e.data, "load_data", ep_data, e.data);
            chk(ep_en == e.n_en, "enable_cycles", ep_en, e.n_en);
            chk(saw_done == e.done, "done_pulse", saw_done, e.done);
            chk(ep_len == e.n_en + 2, "episode_length", ep_len, e.n_en + 2);
        end
        ep_active = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk({gnt, cnt_load, cnt_data, cnt_en, done, busy} == '0, "reset_outputs",
                {gnt, cnt_load, cnt_data, cnt_en, done, busy}, 0);
            ep_active = 1'b0;
        end else begin
            chk(!(cnt_load && cnt_en), "load_en_exclusive", {cnt_load, cnt_en}, 0);
            chk(!(gnt[0] && gnt[1]), "gnt_onehot", gnt, 0);
            if (!busy)
                chk({gnt, cnt_load, cnt_data, cnt_en, done} == '0, "idle_outputs",
                    {gnt, cnt_load, cnt_data, cnt_en, done}, 0);
            if (gnt == 2'b00)
                chk({cnt_load, cnt_en, done} == '0, "ungranted_quiet", {cnt_load, cnt_en, done}, 0);
            else
                chk(busy == 1'b1, "busy_with_gnt", busy, 1);
            if (cnt_load) begin
                chk(!ep_active, "load_inside_episode", ep_active, 0);
                ep_active = 1'b1;
                ep_gnt    = gnt;
                ep_data   = cnt_data;
                ep_en     = 0;
                ep_len    = 1;
            end else if (ep_active) begin
                if (gnt != 2'b00) begin
                    ep_len++;
                    if (cnt_en) ep_en++;
                    chk(gnt == ep_gnt, "gnt_stable", gnt, ep_gnt);
                    if (done != 2'b00) begin
                        chk(done == ep_gnt, "done_owner", done, ep_gnt);
                        finish_ep(1'b1);
                    end
                end else begin
                    finish_ep(1'b0);
                end
            end
        end
        if (finished) begin
            chk(exp_q.size() == 0, "leftover_expected", exp_q.size(), 0);
            chk(timeouts == 0, "timeouts", timeouts, 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    // ---------------- reference model helpers ----------------
    function automatic int span(input logic [W-1:0] s, input logic [W-1:0] t);
        logic [W-1:0] d;
        d = t - s;
        return int'(d);
    endfunction

    function automatic int rr_pick(input logic [1:0] m);
        if (m == 2'b11) return (model_last == 1) ? 0 : 1;
        return m[1] ? 1 : 0;
    endfunction

    task automatic push_exp(input int i, input logic [W-1:0] s, input int n, input bit d);
        exp_t e;
        e.gnt  = (i == 1) ? 2'b10 : 2'b01;
        e.data = s;
        e.n_en = n;
        e.done = d;
        exp_q.push_back(e);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_term(input int i, input logic [W-1:0] v);
        if (i == 0) term_val0 = v;
        else term_val1 = v;
    endtask

    task automatic setup_req(input int i, input logic [W-1:0] s, input logic [W-1:0] t,
                             input bit per, input int tgt, input bit ab,
                             input logic [W-1:0] abv, input bit raise);
        if (i == 0) start_val0 = s;
        else start_val1 = s;
        set_term(i, t);
        periodic[i]    = per;
        permode[i]     = per;
        target[i]      = tgt;
        dones[i]       = 0;
        abort_en[i]    = ab;
        abort_val[i]   = abv;
        raise_other[i] = raise;
    endtask

    task automatic run_txn(input logic [1:0] mask, input int max_cycles);
        int cyc;
        logic [1:0] d_now;
        logic [W-1:0] r;
        cyc = 0;
        req = mask;
        active = mask;
        prev_done = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            d_now = done;
            for (int i = 0; i < 2; i++) begin
                if (active[i]) begin
                    if (prev_done[i]) begin
                        dones[i]++;
                        if (!permode[i] || dones[i] >= target[i]) begin
                            req[i] = 1'b0;
                            active[i] = 1'b0;
                        end else if (raise_other[i] && dones[i] == target[i] - 1) begin
                            req[1-i] = 1'b1;
                            active[1-i] = 1'b1;
                            raise_other[i] = 1'b0;
                        end
                    end
                    if (active[i] && abort_en[i] && gnt[i] && !cnt_load && cnt_value == abort_val[i]) begin
                        req[i] = 1'b0;
                        active[i] = 1'b0;
                    end
                    // latched parameters must make these late changes irrelevant
                    if (active[i] && !permode[i] && gnt[i] && !cnt_load) begin
                        r = W'($urandom);
                        set_term(i, r);
                        periodic[i] = 1'($urandom_range(0, 1));
                    end
                end
            end
            prev_done = d_now;
            if (active == 2'b00 && !busy) break;
            if (cyc >= max_cycles) begin
                timeouts++;
                $display("FAIL txn_timeout: still busy after %0d cycles, required idle", cyc);
                req = 2'b00;
                active = 2'b00;
                break;
            end
        end
        periodic = 2'b00;
    endtask

    // ---------------- scenarios ----------------
    task automatic oneshot(input int i, input logic [W-1:0] s, input logic [W-1:0] t,
                           input bit ab, input int k);
        logic [W-1:0] abv;
        abv = s + W'(k);
        setup_req(i, s, t, 1'b0, 1, ab, abv, 1'b0);
        if (ab) push_exp(i, s, k, 1'b0);
        else push_exp(i, s, span(s, t), 1'b1);
        model_last = i;
        run_txn((i == 1) ? 2'b10 : 2'b01, 1000);
    endtask

    task automatic tie(input logic [W-1:0] s0, input logic [W-1:0] t0,
                       input logic [W-1:0] s1, input logic [W-1:0] t1);
        int first;
        first = rr_pick(2'b11);
        setup_req(0, s0, t0, 1'b0, 1, 1'b0, '0, 1'b0);
        setup_req(1, s1, t1, 1'b0, 1, 1'b0, '0, 1'b0);
        push_exp(first, first == 0 ? s0 : s1, first == 0 ? span(s0, t0) : span(s1, t1), 1'b1);
        push_exp(1 - first, first == 0 ? s1 : s0, first == 0 ? span(s1, t1) : span(s0, t0), 1'b1);
        model_last = 1 - first;
        run_txn(2'b11, 1500);
    endtask

    task automatic periodic_run(input int p, input logic [W-1:0] sp, input logic [W-1:0] tp,
                                input int np, input logic [W-1:0] so, input logic [W-1:0] to);
        setup_req(p, sp, tp, 1'b1, np, 1'b0, '0, 1'b1);
        setup_req(1 - p, so, to, 1'b0, 1, 1'b0, '0, 1'b0);
        for (int n = 0; n < np; n++) push_exp(p, sp, span(sp, tp), 1'b1);
        push_exp(1 - p, so, span(so, to), 1'b1);
        model_last = 1 - p;
        run_txn((p == 1) ? 2'b10 : 2'b01, 2000);
    endtask

    task automatic reset_mid_run();
        int cyc;
        setup_req(0, 8'd0, 8'd9, 1'b0, 1, 1'b0, '0, 1'b0);
        req = 2'b01;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (gnt[0] && !cnt_load && cnt_value == 8'd3) break;
            if (cyc >= 100) begin
                timeouts++;
                $display("FAIL reset_wait_timeout: cnt_value 0x%0h, required 0x3", cnt_value);
                break;
            end
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req = 2'b00;
        active = 2'b00;
        rst_n = 1'b0;
        model_last = 1;
    endtask

    initial begin
        int kind, i, n, np;
        logic [W-1:0] s, t, s2, t2;
        rst_n = 1'b1;
        req = 2'b00;
        start_val0 = '0; start_val1 = '0; term_val0 = '0; term_val1 = '0;
        periodic = 2'b00;
        active = 2'b00; permode = 2'b00; abort_en = 2'b00; raise_other = 2'b00; prev_done = 2'b00;
        model_last = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;

        tie(8'd10, 8'd14, 8'd20, 8'd22);
        tie(8'd30, 8'd31, 8'd40, 8'd40);
        oneshot(0, 8'd5, 8'd8, 1'b0, 0);
        oneshot(1, 8'd250, 8'd2, 1'b0, 0);
        periodic_run(0, 8'd0, 8'd3, 3, 8'd60, 8'd62);
        oneshot(0, 8'd0, 8'd9, 1'b1, 4);
        oneshot(0, 8'd7, 8'd7, 1'b0, 0);
        reset_mid_run();
        tie(8'd100, 8'd103, 8'd200, 8'd201);

        for (int r = 0; r < 40; r++) begin
            kind = int'($urandom_range(0, 3));
            i    = int'($urandom_range(0, 1));
            s    = W'($urandom);
            t    = s + W'($urandom_range(0, 24));
            s2   = W'($urandom);
            t2   = s2 + W'($urandom_range(0, 24));
            n    = span(s, t);
            case (kind)
                0: begin
                    if (n >= 1 && $urandom_range(0, 1) == 1)
                        oneshot(i, s, t, 1'b1, int'($urandom_range(0, n - 1)));
                    else
                        oneshot(i, s, t, 1'b0, 0);
                end
                1: tie(s, t, s2, t2);
                2: begin
                    np = int'($urandom_range(2, 4));
                    periodic_run(i, s, t, np, s2, t2);
                end
                default: oneshot(i, s, W'($urandom), 1'b0, 0);
            endcase
        end

        finished = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL summary_not_reached: monitor did not finish");
        $fatal(1);
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
